ysyx_25030085_wb_arbiter: RTL and testbench
===========================================

Name: ysyx_25030085_wb_arbiter

Overview:
- Write-back controller for the single write port of the 32x32 integer register file.
- Arbitrates between ALU/jump/LUI results and LSU load returns, and drives a registered write port (rf_we/rf_waddr/rf_wdata).
- Keeps a pending-load scoreboard and stalls issue on RAW/WAW hazards against outstanding loads.
- Provides a drain sequence so the pipeline can quiesce before a flush or fence.

Parameters:
- MAX_LOADS, 4: maximum outstanding loads (1..15).
- CNT_W, 4: width of the outstanding-load counter; must hold MAX_LOADS.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rd  in  5  destination register
- issue_is_load  in  1  instruction is a load
- issue_stall  out  1  combinational; decode must hold when 1
- alu_valid  in  1  ALU-class write-back request
- alu_rd  in  5  ALU destination
- alu_data  in  32  ALU result (already muxed: ALU/PC+4/imm)
- alu_ready  out  1  combinational grant to ALU
- lsu_valid  in  1  load data return
- lsu_rd  in  5  load destination
- lsu_data  in  32  load data
- lsu_ready  out  1  combinational grant to LSU
- drain_req  in  1  level; request quiesce
- drain_done  out  1  registered; 1 while drained
- rf_we  out  1  registered write enable
- rf_waddr  out  5  registered write address
- rf_wdata  out  32  registered write data

Behaviour:
- Reset (rst==0 at posedge):
  - pending[31:0]=0, outstanding=0, last_grant=LSU (so ALU wins the first tie), state=RUN.
  - rf_we=0, rf_waddr=0, rf_wdata=0, drain_done=0.
- Arbitration (combinational):
  - Only ALU valid: alu_ready=1. Only LSU valid: lsu_ready=1.
  - Both valid: grant the source not in last_grant (round-robin); the loser's ready=0 and it must hold its request stable.
  - last_grant updates only on a cycle where a grant occurs.
- Write port, 1-cycle latency:
  - On a granted handshake, the next posedge loads rf_waddr=rd and rf_wdata=data.
  - rf_we=1 iff rd!=0. A grant with rd==0 is consumed with rf_we=0.
  - With no grant, rf_we=0 and addr/data hold their last values.
- Scoreboard:
  - Set: on issue_valid & ~issue_stall & issue_is_load & issue_rd!=0, pending[issue_rd] is set.
  - Clear: on an LSU grant, pending[lsu_rd] is cleared at the same posedge the write is registered.
  - Set and clear of the same index in one cycle cannot occur, because issue stalls on pending[rd].
  - pending[0] is never set.
- outstanding counter:
  - +1 on accepted load issue (including rd==0).
  - -1 on LSU grant.
  - Both in the same cycle: unchanged.
- issue_stall = issue_valid & (pending[rs1] | pending[rs2] | pending[rd] | (issue_is_load & outstanding==MAX_LOADS) | state!=RUN).
  - Stall is not qualified by whether rs2 is actually used; this is conservative.
- FSM:
  - RUN: drain_req=1 -> DRAIN.
  - DRAIN: issue blocked; write-back arbitration continues; outstanding==0 and no alu_valid -> DONE.
  - DONE: drain_done=1; drain_req=0 -> RUN and drain_done=0 at the same posedge.
  - drain_req with outstanding==0 and no alu_valid takes 2 cycles to reach DONE (RUN->DRAIN->DONE).
- Reset mid-operation: all state clears; loads still returning after reset are still granted and written, with pending clear redundant. The LSU must be reset alongside.
- Counter underflow (LSU grant with outstanding==0): counter saturates at 0. This is a protocol error, flagged in simulation with $error.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: adds outputs stat_conflict[31:0] (cycles with alu_valid&lsu_valid) and stat_stall[31:0] (cycles with issue_stall=1). Both are wrapping counters, cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0x1234 -> alu_ready=1; next cycle rf_we=1, waddr=5, wdata=0x1234.
- Write to x0: alu_rd=0, data=0xFFFF -> alu_ready=1; next cycle rf_we=0.
- Tie after reset: ALU rd=3 and LSU rd=4 valid together for 2 cycles -> writes x3 then x4; the following tie grants ALU again.
- Load hazard:
  - Issue load rd=7 -> pending[7]=1.
  - Next instruction with rs1=7 -> issue_stall=1.
  - LSU returns rd=7, data=0xAA -> rf write of x7=0xAA; stall drops the cycle after the grant.
- Load cap: 4 load issues with rd=1..4 and no returns -> 5th load stalls (outstanding==4); a non-load with unrelated regs does not stall.
- Drain: with 2 loads outstanding, assert drain_req -> issue_stall=1; after both LSU returns, drain_done=1 next cycle; deassert drain_req -> RUN, stall releases.

Source files
------------

// File: rtl/ysyx_25030085_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: decode issue, ALU/LSU write-back
// requests, drain handshake and the registered register-file write port.
interface ysyx_25030085_wb_arbiter_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_is_load;
  logic        issue_stall;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;

  logic        drain_req;
  logic        drain_done;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output drain_req,
    input  issue_stall, alu_ready, lsu_ready, drain_done,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  drain_req,
    output issue_stall, alu_ready, lsu_ready, drain_done,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ysyx_25030085_wb_arbiter.sv
// Write-back arbiter: round-robin ALU/LSU grant onto one registered RF write
// port, pending-load scoreboard with issue stall, and a RUN/DRAIN/DONE quiesce
// FSM. Define WB_ARB_STATS_EN to add the stat_conflict/stat_stall counters.
module ysyx_25030085_wb_arbiter #(
  parameter int unsigned MAX_LOADS = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25030085_wb_arbiter_if.slave     bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_conflict,
  output logic [31:0]                   stat_stall
`endif
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic       {SRC_ALU, SRC_LSU}        src_e;

  state_e             state_q, state_d;
  src_e               last_grant_q, last_grant_d;
  logic [31:0]        pending_q, pending_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;
  logic               drain_done_q, drain_done_d;

  logic grant_alu, grant_lsu;
  logic at_cap, hazard, issue_stall, load_fire;

  // ALU wins a tie unless it won the previous grant.
  assign grant_alu = bus.alu_valid & (~bus.lsu_valid | (last_grant_q == SRC_LSU));
  assign grant_lsu = bus.lsu_valid & ~grant_alu;

  assign at_cap      = (outstanding_q == CNT_W'(MAX_LOADS));
  assign hazard      = pending_q[bus.issue_rs1] | pending_q[bus.issue_rs2] |
                       pending_q[bus.issue_rd];
  assign issue_stall = bus.issue_valid &
                       (hazard | (bus.issue_is_load & at_cap) | (state_q != S_RUN));
  assign load_fire   = bus.issue_valid & ~issue_stall & bus.issue_is_load;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    last_grant_d  = last_grant_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    state_d       = state_q;

    if (grant_alu) begin
      rf_we_d      = (bus.alu_rd != 5'd0);
      rf_waddr_d   = bus.alu_rd;
      rf_wdata_d   = bus.alu_data;
      last_grant_d = SRC_ALU;
    end else if (grant_lsu) begin
      rf_we_d      = (bus.lsu_rd != 5'd0);
      rf_waddr_d   = bus.lsu_rd;
      rf_wdata_d   = bus.lsu_data;
      last_grant_d = SRC_LSU;
    end

    if (grant_lsu) pending_d[bus.lsu_rd] = 1'b0;
    if (load_fire && (bus.issue_rd != 5'd0)) pending_d[bus.issue_rd] = 1'b1;

    unique case ({load_fire, grant_lsu})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    unique case (state_q)
      S_RUN:   if (bus.drain_req) state_d = S_DRAIN;
      S_DRAIN: if ((outstanding_q == '0) && !bus.alu_valid) state_d = S_DONE;
      S_DONE:  if (!bus.drain_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    drain_done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RUN;
      last_grant_q  <= SRC_LSU;
      pending_q     <= '0;
      outstanding_q <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= 32'd0;
      drain_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      drain_done_q  <= drain_done_d;
    end
  end

  // A load return with nothing outstanding means the LSU was not reset with us.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_a: assert (!(grant_lsu && !load_fire && (outstanding_q == '0)))
        else $error("wb_arbiter: LSU grant with no outstanding load");
    end
  end

  assign bus.issue_stall = issue_stall;
  assign bus.alu_ready   = grant_alu;
  assign bus.lsu_ready   = grant_lsu;
  assign bus.drain_done  = drain_done_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_conflict_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_conflict_q <= 32'd0;
      stat_stall_q    <= 32'd0;
    end else begin
      if (bus.alu_valid && bus.lsu_valid) stat_conflict_q <= stat_conflict_q + 32'd1;
      if (issue_stall)                    stat_stall_q    <= stat_stall_q + 32'd1;
    end
  end

  assign stat_conflict = stat_conflict_q;
  assign stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25030085_wb_arbiter.sv
// Directed bench for the write-back arbiter; expected RF writes are queued as
// requests are granted and compared one cycle later.
module tb_ysyx_25030085_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  wr_t  exp_q[$];

  ysyx_25030085_wb_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_conflict, stat_stall;
`endif

  ysyx_25030085_wb_arbiter #(.MAX_LOADS(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_stall    (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wr_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then compare the registered write port to the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_we",    {31'd0, bus.rf_we}, {31'd0, e.we});
      check("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.addr});
      check("rf_wdata", bus.rf_wdata, e.data);
    end else begin
      check("rf_we_idle", {31'd0, bus.rf_we}, 32'd0);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic ld);
    bus.issue_valid   = v;
    bus.issue_rs1     = rs1;
    bus.issue_rs2     = rs2;
    bus.issue_rd      = rd;
    bus.issue_is_load = ld;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = data;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = data;
  endtask

  task automatic idle();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b0, 5'd0, 32'd0);
    bus.drain_req = 1'b0;
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;

    // Reset state
    rst = 1'b0;
    idle();
    tick();
    tick();
    check("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_drain_done", {31'd0, bus.drain_done}, 32'd0);
    rst = 1'b1;
    settle();
    check("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);

    // ALU only
    set_alu(1'b1, 5'd5, 32'h1234);
    settle();
    check("alu_only_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("alu_only_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    expect_wr(1'b1, 5'd5, 32'h1234);
    tick();

    // Write to x0 is consumed without a write enable
    set_alu(1'b1, 5'd0, 32'hFFFF);
    settle();
    check("x0_ready", {31'd0, bus.alu_ready}, 32'd1);
    expect_wr(1'b0, 5'd0, 32'hFFFF);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    check("hold_wdata", bus.rf_wdata, 32'hFFFF);

    // Tie after reset: ALU first, then LSU, then ALU again
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    settle();
    check("tie_load_issue_stall", {31'd0, bus.issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd3, 32'h33);
    set_lsu(1'b1, 5'd4, 32'h44);
    settle();
    check("tie1_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("tie1_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    expect_wr(1'b1, 5'd3, 32'h33);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    settle();
    check("tie2_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("tie2_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    check("tie2_issue_stall", {31'd0, bus.issue_stall}, 32'd0);
    expect_wr(1'b1, 5'd4, 32'h44);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b1, 5'd3, 32'h3B);
    set_lsu(1'b1, 5'd9, 32'h99);
    settle();
    check("tie3_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("tie3_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    expect_wr(1'b1, 5'd3, 32'h3B);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    check("lsu_only_ready", {31'd0, bus.lsu_ready}, 32'd1);
    expect_wr(1'b1, 5'd9, 32'h99);
    tick();
    set_lsu(1'b0, 5'd0, 32'd0);

    // Load-use hazard
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    settle();
    check("hz_load_stall", {31'd0, bus.issue_stall}, 32'd0);
    tick();
    set_issue(1'b1, 5'd7, 5'd0, 5'd1, 1'b0);
    settle();
    check("hz_raw_stall", {31'd0, bus.issue_stall}, 32'd1);
    set_lsu(1'b1, 5'd7, 32'hAA);
    settle();
    check("hz_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    check("hz_stall_during_grant", {31'd0, bus.issue_stall}, 32'd1);
    expect_wr(1'b1, 5'd7, 32'hAA);
    tick();
    set_lsu(1'b0, 5'd0, 32'd0);
    settle();
    check("hz_stall_released", {31'd0, bus.issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Outstanding-load cap
    for (int i = 1; i <= 4; i++) begin
      set_issue(1'b1, 5'd0, 5'd0, 5'(i), 1'b1);
      settle();
      check("cap_fill_stall", {31'd0, bus.issue_stall}, 32'd0);
      tick();
    end
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    settle();
    check("cap_fifth_load_stall", {31'd0, bus.issue_stall}, 32'd1);
    set_issue(1'b1, 5'd2, 5'd0, 5'd12, 1'b0);
    settle();
    check("cap_rs1_pending_stall", {31'd0, bus.issue_stall}, 32'd1);
    set_issue(1'b1, 5'd10, 5'd11, 5'd12, 1'b0);
    settle();
    check("cap_nonload_stall", {31'd0, bus.issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      set_lsu(1'b1, 5'(i), 32'h100 + 32'(i));
      settle();
      check("cap_return_ready", {31'd0, bus.lsu_ready}, 32'd1);
      expect_wr(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    set_lsu(1'b0, 5'd0, 32'd0);

    // Drain with two loads outstanding
    set_issue(1'b1, 5'd0, 5'd0, 5'd20, 1'b1);
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd21, 1'b1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.drain_req = 1'b1;
    tick();
    set_issue(1'b1, 5'd0, 5'd0, 5'd13, 1'b0);
    settle();
    check("drain_issue_stall", {31'd0, bus.issue_stall}, 32'd1);
    check("drain_not_done", {31'd0, bus.drain_done}, 32'd0);
    set_lsu(1'b1, 5'd20, 32'hD20);
    settle();
    expect_wr(1'b1, 5'd20, 32'hD20);
    tick();
    check("drain_busy1", {31'd0, bus.drain_done}, 32'd0);
    set_lsu(1'b1, 5'd21, 32'hD21);
    settle();
    expect_wr(1'b1, 5'd21, 32'hD21);
    tick();
    set_lsu(1'b0, 5'd0, 32'd0);
    n = 0;
    while (!bus.drain_done && n < 4) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, bus.drain_done}, 32'd1);
    check("drain_latency", 32'(n), 32'd1);
    settle();
    check("done_issue_stall", {31'd0, bus.issue_stall}, 32'd1);
    bus.drain_req = 1'b0;
    tick();
    check("undrain_done_low", {31'd0, bus.drain_done}, 32'd0);
    settle();
    check("undrain_stall_release", {31'd0, bus.issue_stall}, 32'd0);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
